alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined successor to the 8-bit combinational ALU/operand-mux datapath. The block takes a left operand from `inbus` and a right operand from one of `NSRC` side buses or an internal accumulator. It computes one of four operations over `WIDTH` bits and delivers the result plus carry/zero flags through a two-stage valid/ready pipeline. It sits between the operand bus fabric and the result bus, and absorbs downstream backpressure without losing data.

## Interface
- `WIDTH`, 8, datapath width in bits (≥ 2)
- `NSRC`, 2, number of right-operand side buses (≥ 2)
- `SEL_W`, `$clog2(NSRC)`, width of `select_source`
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, synchronous and active-low
- `in_valid` input 1: an operation is offered
- `in_ready` output 1: stage 1 accepts this cycle
- `inbus` input WIDTH: left operand
- `side_bus` input NSRC*WIDTH: side operands; source k is at bits [k*WIDTH +: WIDTH]
- `select_source` input SEL_W: selects the right-operand side bus
- `func` input 3: [1:0] opcode, [2] accumulate mode
- `acc_clr` input 1: synchronous accumulator clear
- `out_valid` output 1: result is valid
- `out_ready` input 1: consumer accepts the result
- `outbus` output WIDTH: result
- `out_carry` output 1: carry or borrow flag
- `out_zero` output 1: result == 0

## Operation
- Opcodes:
  - 00 ADD: `{carry,res} = left + right`, computed at WIDTH+1 bits.
  - 01 SUB: `res = left - right` mod 2^WIDTH; `carry = 1` when `left < right` (unsigned borrow).
  - 10 AND; 11 OR: `carry = 0`.
- Right operand:
  - `func[2]=0`: `side_bus[select_source]`. If `select_source ≥ NSRC`, the right operand is 0.
  - `func[2]=1`: the accumulator register `acc`, ignoring `select_source`; the result is also written to `acc`.
- Stage 1 (S1) registers left, the selected side operand, and func on `in_valid && in_ready`.
- The ALU computes combinationally from S1 registers and `acc`.
- Stage 2 (S2) registers `outbus`, `out_carry` and `out_zero` when S1 advances.
- `acc` is written on the same edge S2 loads an accumulate-mode result. Back-to-back accumulate ops therefore chain with no bubbles: each reads the value written by its predecessor.
- `acc_clr`:
  - Sets `acc` to 0 on the next edge.
  - When it coincides with an accumulate write, the clear wins and the result is still delivered to S2.
  - An accumulate op reaching the ALU in the same cycle as `acc_clr` uses the pre-clear `acc`.
- Handshake:
  - `s1_adv = s1_valid && (!out_valid || out_ready)`.
  - `in_ready = !s1_valid || s1_adv`.
  - S2 holds its data stable while `out_valid && !out_ready`.
  - No transfer is dropped or duplicated.

## Timing
- Latency: an operation accepted at edge N appears on `outbus` with `out_valid=1` after edge N+1 (two registers).
- Throughput: one operation per cycle while `out_ready=1`.
- Backpressure: with `out_ready=0`, at most 2 operations are buffered, one each in S1 and S2. `in_ready` drops the cycle after S1 fills behind a stalled S2.
- Reset (`rst_n=0` at an edge):
  - `out_valid`, `outbus`, `out_carry`, `out_zero` and `acc` become 0, and S1 is emptied.
  - `in_ready` reads 1 from the first cycle after reset.
  - Reset mid-operation discards in-flight data.
- Outputs are registered only; `in_ready` is combinational from `out_ready`.

## Configuration
- `ALU_PIPE_ACC_EN`
  - Defined: the accumulator, `func[2]` accumulate mode and `acc_clr` are as above.
  - Undefined: there is no `acc` register. `func[2]` and `acc_clr` are ignored, the right operand is always the side bus, and there are no side effects between operations.

## Test plan
- Defaults (WIDTH=8, NSRC=2), `out_ready=1`:
  - inbus=0xF0, side0=0x20, sel=0, func=000 → after 2 edges outbus=0x10, carry=1, zero=0.
- SUB borrow: inbus=0x05, side1=0x07, sel=1, func=001 → outbus=0xFE, carry=1; inbus=0x07, side1=0x07 → outbus=0x00, zero=1, carry=0.
- Backpressure:
  - Stream 4 ADDs with `out_ready=0` → `in_ready` drops after 2 accepts and outbus holds the first result.
  - Raise `out_ready` → all 4 results emerge in order with no loss.
- Accumulate (`ALU_PIPE_ACC_EN`): `acc_clr`, then 3 consecutive func=100 ops with inbus=0x03 → outbus 0x03, 0x06, 0x09 on consecutive cycles. Assert `acc_clr` together with the third write → next accumulate op with inbus=0x01 yields 0x01.
- Reset mid-stream: `rst_n=0` for one edge with S1 and S2 full → `out_valid=0`, outbus=0, acc=0; the next accepted op produces only its own result.
- Out-of-range select (NSRC=3, sel=3): inbus=0x55, func=011 → outbus=0x55.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe handshake and operand/result bus bundle.
// master drives operations and out_ready; slave is the ALU pipeline.
interface alu_pipe_if #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 2,
    parameter int SEL_W = $clog2(NSRC)
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      inbus;
    logic [NSRC*WIDTH-1:0] side_bus;
    logic [SEL_W-1:0]      select_source;
    logic [2:0]            func;
    logic                  acc_clr;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      outbus;
    logic                  out_carry;
    logic                  out_zero;

    modport master (
        output in_valid, inbus, side_bus, select_source,
        output func, acc_clr, out_ready,
        input  in_ready, out_valid, outbus, out_carry, out_zero
    );

    modport slave (
        input  in_valid, inbus, side_bus, select_source,
        input  func, acc_clr, out_ready,
        output in_ready, out_valid, outbus, out_carry, out_zero
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: ADD/SUB/AND/OR with carry and zero flags.
// Optional accumulator mode is enabled by defining ALU_PIPE_ACC_EN.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 2,
    parameter int SEL_W = $clog2(NSRC)
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_left;
    logic [WIDTH-1:0] s1_right;
    logic [1:0]       s1_op;
    logic             s1_adv;
    logic [WIDTH-1:0] side_sel;
    logic [WIDTH-1:0] right;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

`ifdef ALU_PIPE_ACC_EN
    logic             s1_acc;
    logic [WIDTH-1:0] acc;
`else
    logic             unused_cfg;
    assign unused_cfg = ^{bus.func[2], bus.acc_clr};
`endif

    assign s1_adv = s1_valid && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s1_adv;

    // Pick the side operand; an out-of-range select yields zero.
    always_comb begin
        side_sel = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.select_source == SEL_W'(k)) begin
                side_sel = bus.side_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // Right operand: accumulator in accumulate mode, else the side bus.
    always_comb begin
`ifdef ALU_PIPE_ACC_EN
        right = s1_acc ? acc : s1_right;
`else
        right = s1_right;
`endif
    end

    // ALU datapath; the top bit of the difference is the unsigned borrow.
    always_comb begin
        sum   = {1'b0, s1_left} + {1'b0, right};
        diff  = {1'b0, s1_left} - {1'b0, right};
        res   = '0;
        carry = 1'b0;
        unique case (s1_op)
            2'b00: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            2'b01: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
            end
            2'b10: res = s1_left & right;
            2'b11: res = s1_left | right;
            default: res = '0;
        endcase
    end

    // Stage 1: capture operands whenever an offer is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_left  <= '0;
            s1_right <= '0;
            s1_op    <= '0;
`ifdef ALU_PIPE_ACC_EN
            s1_acc   <= 1'b0;
`endif
        end else if (bus.in_valid && bus.in_ready) begin
            s1_valid <= 1'b1;
            s1_left  <= bus.inbus;
            s1_right <= side_sel;
            s1_op    <= bus.func[1:0];
`ifdef ALU_PIPE_ACC_EN
            s1_acc   <= bus.func[2];
`endif
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: load the result when S1 advances, hold it while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.outbus    <= '0;
            bus.out_carry <= 1'b0;
            bus.out_zero  <= 1'b0;
        end else if (s1_adv) begin
            bus.out_valid <= 1'b1;
            bus.outbus    <= res;
            bus.out_carry <= carry;
            bus.out_zero  <= (res == '0);
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef ALU_PIPE_ACC_EN
    // Accumulator: clear wins over a coincident accumulate write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (bus.acc_clr) begin
            acc <= '0;
        end else if (s1_adv && s1_acc) begin
            acc <= res;
        end
    end
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (NSRC=2 and NSRC=3 instances).
// Accumulator steps run only when ALU_PIPE_ACC_EN is defined.
module tb_alu_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_pipe_if #(.WIDTH(8), .NSRC(2)) bus ();
    alu_pipe_if #(.WIDTH(8), .NSRC(3)) bus3 ();

    alu_pipe #(.WIDTH(8), .NSRC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    alu_pipe #(.WIDTH(8), .NSRC(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [7:0] a,
                         input logic [7:0] s0,
                         input logic [7:0] s1,
                         input logic       sel,
                         input logic [2:0] f);
        bus.in_valid      = 1'b1;
        bus.inbus         = a;
        bus.side_bus      = {s1, s0};
        bus.select_source = sel;
        bus.func          = f;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_valid       = 1'b0;
        bus.inbus          = '0;
        bus.side_bus       = '0;
        bus.select_source  = '0;
        bus.func           = '0;
        bus.acc_clr        = 1'b0;
        bus.out_ready      = 1'b1;
        bus3.in_valid      = 1'b0;
        bus3.inbus         = '0;
        bus3.side_bus      = '0;
        bus3.select_source = '0;
        bus3.func          = '0;
        bus3.acc_clr       = 1'b0;
        bus3.out_ready     = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
        chk("rst_outbus", 16'(bus.outbus), 16'h0);
        chk("rst_in_ready", 16'(bus.in_ready), 16'h1);

        // ADD with carry out, two-edge latency
        offer(8'hF0, 8'h20, 8'h00, 1'b0, 3'b000);
        step();
        bus.in_valid = 1'b0;
        chk("add_lat_valid", 16'(bus.out_valid), 16'h0);
        step();
        chk("add_valid", 16'(bus.out_valid), 16'h1);
        chk("add_res", 16'(bus.outbus), 16'h10);
        chk("add_carry", 16'(bus.out_carry), 16'h1);
        chk("add_zero", 16'(bus.out_zero), 16'h0);
        step();
        chk("add_drain", 16'(bus.out_valid), 16'h0);

        // SUB borrow, then SUB to zero, back to back
        offer(8'h05, 8'hAA, 8'h07, 1'b1, 3'b001);
        step();
        offer(8'h07, 8'hAA, 8'h07, 1'b1, 3'b001);
        step();
        bus.in_valid = 1'b0;
        chk("sub_b_res", 16'(bus.outbus), 16'hFE);
        chk("sub_b_carry", 16'(bus.out_carry), 16'h1);
        chk("sub_b_zero", 16'(bus.out_zero), 16'h0);
        step();
        chk("sub_z_valid", 16'(bus.out_valid), 16'h1);
        chk("sub_z_res", 16'(bus.outbus), 16'h00);
        chk("sub_z_carry", 16'(bus.out_carry), 16'h0);
        chk("sub_z_zero", 16'(bus.out_zero), 16'h1);

        // AND, OR, and ADD wrapping to zero, streamed
        offer(8'hF0, 8'h3C, 8'h00, 1'b0, 3'b010);
        step();
        offer(8'h81, 8'h00, 8'h42, 1'b1, 3'b011);
        step();
        chk("and_res", 16'(bus.outbus), 16'h30);
        chk("and_carry", 16'(bus.out_carry), 16'h0);
        offer(8'hFF, 8'h01, 8'h00, 1'b0, 3'b000);
        step();
        bus.in_valid = 1'b0;
        chk("or_res", 16'(bus.outbus), 16'hC3);
        chk("or_carry", 16'(bus.out_carry), 16'h0);
        step();
        chk("wrap_res", 16'(bus.outbus), 16'h00);
        chk("wrap_carry", 16'(bus.out_carry), 16'h1);
        chk("wrap_zero", 16'(bus.out_zero), 16'h1);
        step();

        // Backpressure: 4 ADDs, only 2 buffered while stalled
        bus.out_ready = 1'b0;
        offer(8'h01, 8'h10, 8'h00, 1'b0, 3'b000);
        chk("bp_rdy0", 16'(bus.in_ready), 16'h1);
        step();
        chk("bp_rdy1", 16'(bus.in_ready), 16'h1);
        offer(8'h02, 8'h10, 8'h00, 1'b0, 3'b000);
        step();
        chk("bp_rdy2", 16'(bus.in_ready), 16'h0);
        chk("bp_hold_a", 16'(bus.outbus), 16'h11);
        offer(8'h03, 8'h10, 8'h00, 1'b0, 3'b000);
        step();
        chk("bp_rdy3", 16'(bus.in_ready), 16'h0);
        chk("bp_hold_v", 16'(bus.out_valid), 16'h1);
        chk("bp_hold_b", 16'(bus.outbus), 16'h11);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb", 16'(bus.in_ready), 16'h1);
        step();
        chk("bp_out2", 16'(bus.outbus), 16'h12);
        offer(8'h04, 8'h10, 8'h00, 1'b0, 3'b000);
        step();
        bus.in_valid = 1'b0;
        chk("bp_out3", 16'(bus.outbus), 16'h13);
        step();
        chk("bp_out4", 16'(bus.outbus), 16'h14);
        chk("bp_out4_v", 16'(bus.out_valid), 16'h1);
        step();
        chk("bp_empty", 16'(bus.out_valid), 16'h0);

        // Reset with S1 and S2 both full
        bus.out_ready = 1'b0;
        offer(8'h40, 8'h01, 8'h00, 1'b0, 3'b000);
        step();
        offer(8'h50, 8'h01, 8'h00, 1'b0, 3'b000);
        step();
        bus.in_valid = 1'b0;
        chk("mr_full", 16'(bus.in_ready), 16'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mr_valid", 16'(bus.out_valid), 16'h0);
        chk("mr_outbus", 16'(bus.outbus), 16'h0);
        chk("mr_in_ready", 16'(bus.in_ready), 16'h1);
        bus.out_ready = 1'b1;
        offer(8'h22, 8'h11, 8'h00, 1'b0, 3'b000);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("mr_new_v", 16'(bus.out_valid), 16'h1);
        chk("mr_new_res", 16'(bus.outbus), 16'h33);
        step();
        chk("mr_no_stale", 16'(bus.out_valid), 16'h0);

`ifdef ALU_PIPE_ACC_EN
        // Accumulator chain, then clear coinciding with a write
        bus.acc_clr = 1'b1;
        step();
        bus.acc_clr = 1'b0;
        offer(8'h03, 8'hEE, 8'hDD, 1'b1, 3'b100);
        step();
        step();
        chk("acc_1", 16'(bus.outbus), 16'h03);
        step();
        chk("acc_2", 16'(bus.outbus), 16'h06);
        bus.acc_clr = 1'b1;
        offer(8'h01, 8'hEE, 8'hDD, 1'b1, 3'b100);
        step();
        bus.acc_clr  = 1'b0;
        bus.in_valid = 1'b0;
        chk("acc_3", 16'(bus.outbus), 16'h09);
        chk("acc_3_v", 16'(bus.out_valid), 16'h1);
        step();
        chk("acc_clr", 16'(bus.outbus), 16'h01);
        step();
`endif

        // Out-of-range and in-range select on the NSRC=3 instance
        bus3.in_valid      = 1'b1;
        bus3.inbus         = 8'h55;
        bus3.side_bus      = {8'h80, 8'hBB, 8'hCC};
        bus3.select_source = 2'd3;
        bus3.func          = 3'b011;
        step();
        bus3.inbus         = 8'h01;
        bus3.select_source = 2'd2;
        step();
        bus3.in_valid = 1'b0;
        chk("oor_res", 16'(bus3.outbus), 16'h55);
        chk("oor_carry", 16'(bus3.out_carry), 16'h0);
        chk("oor_zero", 16'(bus3.out_zero), 16'h0);
        step();
        chk("sel2_res", 16'(bus3.outbus), 16'h81);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
